// File: rtl/relu_frame_buffer_pkg.sv
// relu_frame_buffer_pkg: shared state type and index-width helper for relu_frame_buffer
package relu_frame_buffer_pkg;
  typedef enum logic {FILL, HOLD} state_t;
  // Floors at 1 bit so a single-slot frame still gets a legal index register
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/relu_unit.sv
// relu_unit: per-pixel processing; clamps negatives to zero when RELU_FRAME_BUFFER_RELU_EN is defined
module relu_unit #(
  parameter int BITWIDTH = 8
) (
  input  logic [BITWIDTH-1:0] pix_i,
  output logic [BITWIDTH-1:0] pix_o
);
`ifdef RELU_FRAME_BUFFER_RELU_EN
  assign pix_o = pix_i[BITWIDTH-1] ? '0 : pix_i;
`else
  assign pix_o = pix_i;
`endif
endmodule

// File: rtl/relu_frame_buffer.sv
// relu_frame_buffer: collects a raster pixel stream into one flattened frame and holds it for the pooling stage.
// Pixel processing is selected by macro RELU_FRAME_BUFFER_RELU_EN (see relu_unit).
module relu_frame_buffer
  import relu_frame_buffer_pkg::*;
#(
  parameter int BITWIDTH    = 8,
  parameter int DATAWIDTH   = 28,
  parameter int DATAHEIGHT  = 28,
  parameter int DATACHANNEL = 3
) (
  input  logic                                                    clk,
  input  logic                                                    rst_n,
  input  logic                                                    in_valid,
  output logic                                                    in_ready,
  input  logic                                                    in_sof,
  input  logic [BITWIDTH-1:0]                                     in_data,
  output logic                                                    out_valid,
  input  logic                                                    out_ready,
  output logic [BITWIDTH*DATAWIDTH*DATAHEIGHT*DATACHANNEL-1:0]    out_data,
  output logic                                                    frame_abort
);
  localparam int N  = DATAWIDTH * DATAHEIGHT * DATACHANNEL;
  localparam int IW = idx_width(N);
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, wr_idx;
  logic [N*BITWIDTH-1:0] data_q;
  logic [BITWIDTH-1:0] pix;
  logic abort_q, abort_d, accept, last;
  relu_unit #(.BITWIDTH(BITWIDTH)) u_relu (.pix_i(in_data), .pix_o(pix));
  // A start-of-frame beat always lands in slot 0, resynchronising the index
  always_comb begin
    accept  = in_valid && state_q == FILL;
    wr_idx  = in_sof ? '0 : idx_q;
    last    = wr_idx == IW'(N - 1);
    abort_d = accept && in_sof && idx_q != '0;
    idx_d   = accept ? (last ? '0 : wr_idx + 1'b1) : idx_q;
    state_d = accept ? (last ? HOLD : FILL) : (state_q == HOLD && out_ready) ? FILL : state_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FILL;
      idx_q   <= '0;
      abort_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      abort_q <= abort_d;
      if (accept) data_q[int'(wr_idx)*BITWIDTH +: BITWIDTH] <= pix;
    end
  end
  assign in_ready    = state_q == FILL;
  assign out_valid   = state_q == HOLD;
  assign out_data    = data_q;
  assign frame_abort = abort_q;
endmodule

// File: tb/tb_relu_frame_buffer.sv
// tb_relu_frame_buffer: directed self-checking bench for relu_frame_buffer (8-bit, 4x4x2 frame).
module tb_relu_frame_buffer;
  localparam int BW = 8;
  localparam int N  = 32;
  localparam int FW = BW * N;
  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, in_sof, out_valid, out_ready, frame_abort;
  logic [BW-1:0] in_data;
  logic [FW-1:0] out_data, exp_frame;
  int checks = 0;
  int errors = 0;
  relu_frame_buffer #(.BITWIDTH(BW), .DATAWIDTH(4), .DATAHEIGHT(4), .DATACHANNEL(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .frame_abort(frame_abort)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask
  task automatic send(input logic [BW-1:0] v, input logic sof);
    in_valid = 1'b1;
    in_data  = v;
    in_sof   = sof;
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask
  initial begin
    logic [BW-1:0] v;
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", FW'(out_valid), FW'(0));
    chk("rst_abort", FW'(frame_abort), FW'(0));
    chk("rst_out_data", out_data, '0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", FW'(in_ready), FW'(1));
    // frame of 0..31, consumed immediately
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      send(BW'(i), i == 0);
      exp_frame[i*BW +: BW] = BW'(i);
      if (i == N - 2) chk("ramp_no_early_valid", FW'(out_valid), FW'(0));
    end
    chk("ramp_out_valid", FW'(out_valid), FW'(1));
    chk("ramp_in_ready_hold", FW'(in_ready), FW'(0));
    chk("ramp_data", out_data, exp_frame);
    @(negedge clk);
    chk("ramp_back_fill_valid", FW'(out_valid), FW'(0));
    chk("ramp_back_fill_ready", FW'(in_ready), FW'(1));
    // backpressure: hold for 5 cycles while junk is offered on the input
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      v = BW'(i * 7 + 100);
      send(v, i == 0);
      exp_frame[i*BW +: BW] = v;
    end
    in_valid = 1'b1; in_data = 8'hAA;
    for (int c = 0; c < 5; c++) begin
      chk("bp_in_ready", FW'(in_ready), FW'(0));
      chk("bp_out_valid", FW'(out_valid), FW'(1));
      chk("bp_data_stable", out_data, exp_frame);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_release_ready", FW'(in_ready), FW'(1));
    chk("bp_release_valid", FW'(out_valid), FW'(0));
    chk("bp_data_after", out_data, exp_frame);
    // negative pixels
    for (int i = 0; i < N; i++) begin
      send(8'hF6, i == 0);
`ifdef RELU_FRAME_BUFFER_RELU_EN
      exp_frame[i*BW +: BW] = 8'h00;
`else
      exp_frame[i*BW +: BW] = 8'hF6;
`endif
    end
    chk("neg_out_valid", FW'(out_valid), FW'(1));
    chk("neg_data", out_data, exp_frame);
    @(negedge clk);
    // resync: 10 beats then a fresh sof
    for (int i = 0; i < 10; i++) send(BW'(8'h10 + i), i == 0);
    chk("pre_abort_quiet", FW'(frame_abort), FW'(0));
    send(8'h55, 1'b1);
    chk("abort_pulse", FW'(frame_abort), FW'(1));
    @(negedge clk);
    chk("abort_single", FW'(frame_abort), FW'(0));
    exp_frame[0 +: BW] = 8'h55;
    for (int i = 1; i < N; i++) begin
      v = BW'(8'hC0 + i);
      send(v, 1'b0);
      exp_frame[i*BW +: BW] = v;
      if (i == N - 2) chk("resync_no_early_valid", FW'(out_valid), FW'(0));
    end
    chk("resync_out_valid", FW'(out_valid), FW'(1));
    chk("resync_data", out_data, exp_frame);
    @(negedge clk);
    // reset mid-frame after 21 beats
    for (int i = 0; i <= 20; i++) send(BW'(8'h80 + i), i == 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_data", out_data, '0);
    chk("midrst_valid", FW'(out_valid), FW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_data", out_data, '0);
    chk("postrst_ready", FW'(in_ready), FW'(1));
    for (int i = 0; i < N; i++) begin
      v = BW'(8'h20 + 3 * i);
      send(v, i == 0);
      exp_frame[i*BW +: BW] = v;
      if (i == 0) chk("postrst_no_abort", FW'(frame_abort), FW'(0));
      chk("postrst_valid_seq", FW'(out_valid), FW'(i == N - 1));
    end
    chk("postrst_data_frame", out_data, exp_frame);
    @(negedge clk);
    chk("postrst_single_valid", FW'(out_valid), FW'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
